delay_sched: RTL
================

# delay_sched

Round-robin scheduler that shares a single delay-timer datapath among NREQ requesters. Each requester raises a request with its own delay length. The block grants the timer to one requester at a time, counts the delay down, and returns a one-cycle done pulse to the owner. It sits between the requesting control FSMs and the shared timer, and flags illegal zero-length requests on err.

## Interface
- NREQ, 4, number of requesters (2..8)
- CBITS, 15, width of delay length and down-counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  level request per requester; hold until done
- len  in  NREQ*CBITS  delay length per requester; slice i = len[i*CBITS +: CBITS]
- grant  out  NREQ  one-hot, owner of the timer; all zero when idle
- done  out  NREQ  one-cycle pulse to the owner on its final count cycle
- busy  out  1  timer in use
- cur_id  out  clog2(NREQ)  index of current owner; 0 when idle
- remain  out  CBITS  cycles left including the current one; 0 when idle
- err  out  1  one-cycle pulse on a zero-length request

## Operation
- States: IDLE, COUNT.
- Reset values: grant=0, done=0, busy=0, cur_id=0, remain=0, err=0. Round-robin pointer=0, state=IDLE.
- IDLE:
  - Scan req starting at the pointer, wrapping modulo NREQ. The first set bit wins.
  - Winner with L = len slice != 0: go to COUNT. Register grant[w]=1, cur_id=w, remain=L, busy=1. Pointer = (w+1) mod NREQ.
  - Winner with L = 0: pulse err next cycle. No grant. Pointer = (w+1) mod NREQ. Stay in IDLE.
  - No req: stay in IDLE. Outputs stay at reset values.
- COUNT:
  - remain decrements by 1 each cycle.
  - The cycle with remain==1 asserts done[cur_id] combinationally from registered state. The next cycle goes to IDLE with grant=0, busy=0, remain=0.
  - Abort: if remain>1 and req[cur_id]==0 is sampled, go to IDLE next cycle. No done is issued. Pointer is unchanged (already advanced).
  - A req drop in the remain==1 cycle is ignored; done is still issued.
- len is sampled only at grant. Later changes to any len slice do not affect the running count.
- Requests from non-owners during COUNT are held pending. They are not lost and carry no priority memory beyond the pointer.
- No arithmetic wrap: remain never decrements below 1 inside COUNT. L max = 2^CBITS-1.
- rst in any state, including mid-count, returns everything to reset values on the next edge. A done pending for that cycle is suppressed.

## Timing
- Request sampled in IDLE at cycle t with length L≥1:
  - grant, busy, cur_id valid t+1..t+L
  - remain = L at t+1, 1 at t+L
  - done pulse at t+L
  - idle at t+L+1
- L=1: grant and done both at t+1.
- Back-to-back: the next grant is earliest at t+L+2. The IDLE cycle t+L+1 performs arbitration.
- Zero-length winner at t: err at t+1. A new arbitration also runs at t+1, so a grant to another requester can appear at t+2.
- Abort when req[cur] is sampled low at cycle c: grant=0 and busy=0 at c+1.
- done and grant are never asserted for different indices in the same cycle. At most one done bit is high per cycle.

## Test plan
- Single request: req=4'b0001, len0=3 at t → grant=0001 t+1..t+3, remain 3,2,1, done=0001 at t+3, busy=0 at t+4.
- Round-robin: req=4'b1111 held, all len=2 → grant order 0,1,2,3,0; each grant lasts 2 cycles with a 1-cycle idle gap between grants.
- Zero length: req=4'b0011, len0=0, len1=5, pointer=0 → err at t+1, grant=0010 t+2..t+6, done=0010 at t+6, no grant ever to requester 0.
- Abort: req0 with len0=10, drop req0 at the third grant cycle → grant=0 next cycle, no done, next requester served; dropping req0 on the remain==1 cycle still yields done.
- Reset mid-count: len2=100, assert rst when remain=50 → all outputs 0 next cycle, pointer=0; a subsequent req=1000 is granted requester 3 at t+1.
- Boundary length: len0=32767 (CBITS=15) → done exactly 32767 cycles after grant start, no wrap; len change mid-count has no effect.

Source files
------------

// File: rtl/delay_sched.sv
// delay_sched: round-robin owner of one shared delay timer.
// Grants one requester, counts its delay down, pulses done.
module delay_sched #(
  parameter int NREQ  = 4,
  parameter int CBITS = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CBITS-1:0]    len,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  cur_id,
  output logic [CBITS-1:0]         remain,
  output logic                     err
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    cur_n;
  logic [NREQ-1:0]  grant_n;
  logic [CBITS-1:0] remain_n;
  logic             err_n;

  logic             found;
  logic [IW-1:0]    win;
  logic [IW-1:0]    win_nxt;
  logic [CBITS-1:0] win_len;
  int               idx;

  // scan req from the pointer, wrapping, first set bit wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    win_len = len[int'(win)*CBITS +: CBITS];
    win_nxt = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
  end

  // next state: arbitrate when idle, count down when owned
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    cur_n    = cur_id;
    grant_n  = grant;
    remain_n = remain;
    err_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          ptr_n = win_nxt;
          if (win_len == '0) begin
            err_n = 1'b1;
          end else begin
            state_n  = COUNT;
            grant_n  = {{(NREQ-1){1'b0}}, 1'b1} << win;
            cur_n    = win;
            remain_n = win_len;
          end
        end
      end
      COUNT: begin
        if (remain == CBITS'(1) || !req[cur_id]) begin
          state_n  = IDLE;
          grant_n  = '0;
          cur_n    = '0;
          remain_n = '0;
        end else begin
          remain_n = remain - CBITS'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cur_id <= '0;
      grant  <= '0;
      remain <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cur_id <= cur_n;
      grant  <= grant_n;
      remain <= remain_n;
      err    <= err_n;
    end
  end

  assign busy = (state == COUNT);
  assign done = (busy && remain == CBITS'(1) && !rst) ? grant : '0;

endmodule
